// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - mode codes and timing geometry for the multi-mode VGA generator
// Exports vga_mode_t, vga_timing_t, the per-mode timing constants and the
// lookup helpers mode_timing() and mode_sync_pol().
package vga_pkg;

   localparam int VGA_W = 11;

   typedef enum logic [1:0] {
      MODE_640  = 2'd0,
      MODE_800  = 2'd1,
      MODE_1024 = 2'd2
   } vga_mode_t;

   typedef struct packed {
      logic [VGA_W-1:0] h_vis;
      logic [VGA_W-1:0] h_sync_start;
      logic [VGA_W-1:0] h_sync_end;
      logic [VGA_W-1:0] h_total;
      logic [VGA_W-1:0] v_vis;
      logic [VGA_W-1:0] v_sync_start;
      logic [VGA_W-1:0] v_sync_end;
      logic [VGA_W-1:0] v_total;
      logic             sync_pol;   // 1 = sync pulses high, 0 = sync pulses low
   } vga_timing_t;

   localparam logic POL_NEG = 1'b0;
   localparam logic POL_POS = 1'b1;

   localparam vga_timing_t VGA_640 = '{
      h_vis: 11'd640,  h_sync_start: 11'd656,  h_sync_end: 11'd752,  h_total: 11'd800,
      v_vis: 11'd480,  v_sync_start: 11'd490,  v_sync_end: 11'd492,  v_total: 11'd525,
      sync_pol: POL_NEG};

   localparam vga_timing_t VGA_800 = '{
      h_vis: 11'd800,  h_sync_start: 11'd840,  h_sync_end: 11'd968,  h_total: 11'd1056,
      v_vis: 11'd600,  v_sync_start: 11'd601,  v_sync_end: 11'd605,  v_total: 11'd628,
      sync_pol: POL_POS};

   localparam vga_timing_t VGA_1024 = '{
      h_vis: 11'd1024, h_sync_start: 11'd1048, h_sync_end: 11'd1184, h_total: 11'd1344,
      v_vis: 11'd768,  v_sync_start: 11'd771,  v_sync_end: 11'd777,  v_total: 11'd806,
      sync_pol: POL_NEG};

   // Code 3 is never made active; it maps to the 1024x768 entry so the
   // lookup stays total.
   function automatic vga_timing_t mode_timing(input logic [1:0] mode);
      case (mode)
         MODE_640: return VGA_640;
         MODE_800: return VGA_800;
         default:  return VGA_1024;
      endcase
   endfunction

   function automatic logic mode_sync_pol(input logic [1:0] mode);
      case (mode)
         MODE_640: return VGA_640.sync_pol;
         MODE_800: return VGA_800.sync_pol;
         default:  return VGA_1024.sync_pol;
      endcase
   endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// rtl/vga_mode_rom.sv - combinational mode code to timing geometry lookup
// Ports: mode (2-bit mode code) -> timing (vga_timing_t for that mode).
module vga_mode_rom
   import vga_pkg::*;
(
   input  logic [1:0]  mode,
   output vga_timing_t timing
);

   assign timing = mode_timing(mode);

endmodule

// File: rtl/vga_timing_multi.sv
// rtl/vga_timing_multi.sv - multi-mode VGA counter/sync generator with frame-aligned mode switching
// Ports: clk, rst_n (async, active low), pix_en (count enable),
//        mode_req_valid/mode_req_sel (mode change request),
//        hcount/vcount, hsync/vsync, hblnk/vblnk (registered timing),
//        frame_start, mode_ack, mode_err (one-cycle pulses), mode_active.
module vga_timing_multi
   import vga_pkg::*;
#(
   parameter int CNT_W        = 11,
   parameter int DEFAULT_MODE = 2
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   input  logic             mode_req_valid,
   input  logic [1:0]       mode_req_sel,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             frame_start,
   output logic             mode_ack,
   output logic             mode_err,
   output logic [1:0]       mode_active
);

   localparam logic [1:0] DEF_MODE = DEFAULT_MODE[1:0];
   localparam logic       DEF_POL  = mode_sync_pol(DEF_MODE);

   logic [1:0]  mode_q;
   logic        pend_valid;
   logic [1:0]  pend_sel;
   vga_timing_t cur_t;

   logic             h_last;
   logic             v_last;
   logic             boundary;
   logic             apply;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   logic             pol_nxt;
   logic             hsync_nxt;
   logic             vsync_nxt;
   logic             hblnk_nxt;
   logic             vblnk_nxt;
   logic             req_ok;
   logic             req_bad;

   vga_mode_rom u_rom (
      .mode   (mode_q),
      .timing (cur_t)
   );

   always_comb begin
      h_last   = (hcount == CNT_W'(cur_t.h_total) - CNT_W'(1));
      v_last   = (vcount == CNT_W'(cur_t.v_total) - CNT_W'(1));
      boundary = pix_en & h_last & v_last;
      apply    = boundary & pend_valid;

      h_nxt = h_last ? '0 : hcount + CNT_W'(1);
      v_nxt = vcount;
      if (h_last) begin
         v_nxt = v_last ? '0 : vcount + CNT_W'(1);
      end

      // On a mode switch the counters land on (0,0), which is visible and
      // outside the sync window in every mode, so the old geometry decodes
      // it correctly; only the polarity has to come from the incoming mode.
      pol_nxt   = apply ? mode_sync_pol(pend_sel) : cur_t.sync_pol;
      hblnk_nxt = (h_nxt >= CNT_W'(cur_t.h_vis));
      vblnk_nxt = (v_nxt >= CNT_W'(cur_t.v_vis));
      hsync_nxt = ((h_nxt >= CNT_W'(cur_t.h_sync_start)) && (h_nxt < CNT_W'(cur_t.h_sync_end)))
                  ? pol_nxt : ~pol_nxt;
      vsync_nxt = ((v_nxt >= CNT_W'(cur_t.v_sync_start)) && (v_nxt < CNT_W'(cur_t.v_sync_end)))
                  ? pol_nxt : ~pol_nxt;

      req_ok  = mode_req_valid && (mode_req_sel != 2'd3);
      req_bad = mode_req_valid && (mode_req_sel == 2'd3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount      <= '0;
         vcount      <= '0;
         hsync       <= ~DEF_POL;
         vsync       <= ~DEF_POL;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         frame_start <= 1'b0;
         mode_ack    <= 1'b0;
         mode_err    <= 1'b0;
         mode_q      <= DEF_MODE;
         pend_valid  <= 1'b0;
         pend_sel    <= DEF_MODE;
      end else begin
         frame_start <= boundary;
         mode_ack    <= apply;
         mode_err    <= req_bad;

         if (pix_en) begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hsync  <= hsync_nxt;
            vsync  <= vsync_nxt;
            hblnk  <= hblnk_nxt;
            vblnk  <= vblnk_nxt;
            if (apply) begin
               mode_q <= pend_sel;
            end
         end

         // A request landing on the boundary cycle refills pending after the
         // old entry is consumed, so it waits for the following boundary.
         if (req_ok) begin
            pend_valid <= 1'b1;
            pend_sel   <= mode_req_sel;
         end else if (apply) begin
            pend_valid <= 1'b0;
         end
      end
   end

   assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
// tb/tb_vga_timing_multi.sv - self-checking bench for vga_timing_multi
module tb_vga_timing_multi;

   localparam int CNT_W = 11;
   localparam int X     = -1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pix_en = 1'b0;
   logic             mode_req_valid = 1'b0;
   logic [1:0]       mode_req_sel = 2'd0;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hsync, vsync, hblnk, vblnk;
   logic             frame_start, mode_ack, mode_err;
   logic [1:0]       mode_active;

   vga_timing_multi #(.CNT_W(CNT_W), .DEFAULT_MODE(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pix_en         (pix_en),
      .mode_req_valid (mode_req_valid),
      .mode_req_sel   (mode_req_sel),
      .hcount         (hcount),
      .vcount         (vcount),
      .hsync          (hsync),
      .vsync          (vsync),
      .hblnk          (hblnk),
      .vblnk          (vblnk),
      .frame_start    (frame_start),
      .mode_ack       (mode_ack),
      .mode_err       (mode_err),
      .mode_active    (mode_active)
   );

   always #5 clk = ~clk;

   // Reference timing table, indexed by mode code.
   int h_vis [3] = '{640, 800, 1024};
   int h_ss  [3] = '{656, 840, 1048};
   int h_se  [3] = '{752, 968, 1184};
   int h_tot [3] = '{800, 1056, 1344};
   int v_vis [3] = '{480, 600, 768};
   int v_ss  [3] = '{490, 601, 771};
   int v_se  [3] = '{492, 605, 777};
   int v_tot [3] = '{525, 628, 806};
   int pos   [3] = '{0, 1, 0};

   typedef struct {
      int h; int v; int rsel;
      int hs; int hb; int vs; int vb;
      int mode; int fs; int ack; int err; int tog;
   } vec_t;

   vec_t  vecs[$];
   int    checks = 0;
   int    errors = 0;
   int    mism = 0;
   string first_mism = "";
   int    cyc = 0;
   int    fs_cyc[$];
   int    ack_cnt = 0;
   bit    tog = 1'b0;
   bit    abort = 1'b0;

   // model state
   int mh, mv, mm, mpsel;
   bit mpend, m_fs, m_ack, m_err;

   function automatic vec_t mk(input int h, input int v, input int rsel,
                               input int hs, input int hb, input int vs, input int vb,
                               input int mode, input int fs, input int ack, input int err,
                               input int tg);
      vec_t r;
      r.h = h; r.v = v; r.rsel = rsel;
      r.hs = hs; r.hb = hb; r.vs = vs; r.vb = vb;
      r.mode = mode; r.fs = fs; r.ack = ack; r.err = err; r.tog = tg;
      return r;
   endfunction

   function automatic int e_hs();
      return (mh >= h_ss[mm] && mh < h_se[mm]) ? pos[mm] : 1 - pos[mm];
   endfunction
   function automatic int e_vs();
      return (mv >= v_ss[mm] && mv < v_se[mm]) ? pos[mm] : 1 - pos[mm];
   endfunction
   function automatic int e_hb();
      return (mh >= h_vis[mm]) ? 1 : 0;
   endfunction
   function automatic int e_vb();
      return (mv >= v_vis[mm]) ? 1 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mh = 0; mv = 0; mm = 2; mpsel = 0;
      mpend = 1'b0; m_fs = 1'b0; m_ack = 1'b0; m_err = 1'b0;
   endtask

   // One clock: advance the model with the inputs present at the edge,
   // then compare every DUT output 1 time unit after the edge.
   task automatic step();
      bit bnd;
      bnd = 1'b0;
      @(posedge clk);
      m_err = mode_req_valid && (mode_req_sel == 2'd3);
      m_fs  = 1'b0;
      m_ack = 1'b0;
      if (pix_en) begin
         bnd = (mh == h_tot[mm] - 1) && (mv == v_tot[mm] - 1);
         if (mh == h_tot[mm] - 1) begin
            mh = 0;
            if (mv == v_tot[mm] - 1) mv = 0;
            else mv++;
         end else begin
            mh++;
         end
         if (bnd) begin
            m_fs = 1'b1;
            if (mpend) begin
               mm = mpsel; mpend = 1'b0; m_ack = 1'b1;
            end
         end
      end
      if (mode_req_valid && mode_req_sel != 2'd3) begin
         mpend = 1'b1;
         mpsel = int'(mode_req_sel);
      end
      #1;
      cyc++;
      if (int'(hcount) != mh || int'(vcount) != mv || int'(hsync) != e_hs() ||
          int'(vsync) != e_vs() || int'(hblnk) != e_hb() || int'(vblnk) != e_vb() ||
          int'(mode_active) != mm || frame_start != m_fs || mode_ack != m_ack ||
          mode_err != m_err) begin
         mism++;
         if (first_mism == "")
            first_mism = $sformatf("cyc=%0d h=%0d/%0d v=%0d/%0d hs=%0d/%0d vs=%0d/%0d hb=%0d/%0d vb=%0d/%0d mode=%0d/%0d fs=%0d/%0d ack=%0d/%0d err=%0d/%0d",
               cyc, hcount, mh, vcount, mv, hsync, e_hs(), vsync, e_vs(), hblnk, e_hb(),
               vblnk, e_vb(), mode_active, mm, frame_start, m_fs, mode_ack, m_ack, mode_err, m_err);
      end
      if (frame_start) fs_cyc.push_back(cyc);
      if (mode_ack) ack_cnt++;
      mode_req_valid = 1'b0;
      if (tog) pix_en = !pix_en;
   endtask

   task automatic run_until(input int h, input int v);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(mh == h && mv == v) && n < 1200000);
      if (!(mh == h && mv == v)) begin
         check($sformatf("reach_%0d_%0d_timeout", h, v), mh * 4096 + mv, h * 4096 + v);
         abort = 1'b1;
      end
   endtask

   initial begin
      #(64'd60_000_000);
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      //            h     v    rsel hs hb vs vb mode fs ack err tog
      // 1024x768 frame: sync/blank edges, requests 1 -> 3 -> 0 mid-frame
      vecs.push_back(mk(1023,   0, X, 1, 0, 1, 0, 2, 0, 0, 0, X));
      vecs.push_back(mk(1024,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk(1047,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk(1048,   0, X, 0, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk(1183,   0, X, 0, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk(1184,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk(1343,   0, X, 1, 1, 1, 0, X, X, X, X, X));
      vecs.push_back(mk(   0,   1, X, 1, 0, 1, 0, X, X, X, X, X));
      vecs.push_back(mk(   0, 100, 1, X, X, X, X, 2, X, X, X, X));
      vecs.push_back(mk(   0, 101, 3, X, X, X, X, 2, X, X, X, X));
      vecs.push_back(mk(   1, 101, X, X, X, X, X, 2, X, X, 1, X));
      vecs.push_back(mk(   2, 101, X, X, X, X, X, 2, X, X, 0, X));
      vecs.push_back(mk(   0, 200, 0, X, X, X, X, 2, X, X, X, X));
      vecs.push_back(mk(   0, 767, X, 1, 0, 1, 0, X, X, X, X, X));
      vecs.push_back(mk(   0, 768, X, 1, 0, 1, 1, X, X, X, X, X));
      vecs.push_back(mk(   0, 770, X, X, X, 1, 1, X, X, X, X, X));
      vecs.push_back(mk(   0, 771, X, X, X, 0, 1, X, X, X, X, X));
      vecs.push_back(mk(1343, 776, X, 1, 1, 0, 1, X, X, X, X, X));
      vecs.push_back(mk(   0, 777, X, X, X, 1, 1, X, X, X, X, X));
      vecs.push_back(mk(1343, 805, X, 1, 1, 1, 1, 2, 0, 0, 0, X));
      vecs.push_back(mk(   0,   0, X, 1, 0, 1, 0, 0, 1, 1, 0, X));
      vecs.push_back(mk(   1,   0, X, X, X, X, X, 0, 0, 0, X, X));
      // 640x480 frame: edges, invalid request, request on the boundary cycle
      vecs.push_back(mk( 639,   0, X, 1, 0, X, X, X, X, X, X, X));
      vecs.push_back(mk( 640,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 655,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 656,   0, X, 0, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 751,   0, X, 0, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 752,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk(   0, 300, 3, X, X, X, X, 0, X, X, X, X));
      vecs.push_back(mk(   1, 300, X, X, X, X, X, 0, X, X, 1, X));
      vecs.push_back(mk(   0, 479, X, X, X, 1, 0, X, X, X, X, X));
      vecs.push_back(mk(   0, 480, X, X, X, 1, 1, X, X, X, X, X));
      vecs.push_back(mk(   0, 489, X, X, X, 1, 1, X, X, X, X, X));
      vecs.push_back(mk(   0, 490, X, X, X, 0, 1, X, X, X, X, X));
      vecs.push_back(mk( 799, 491, X, 1, 1, 0, 1, X, X, X, X, X));
      vecs.push_back(mk(   0, 492, X, X, X, 1, 1, X, X, X, X, X));
      vecs.push_back(mk( 799, 524, 1, 1, 1, 1, 1, 0, 0, 0, X, X));
      vecs.push_back(mk(   0,   0, X, 1, 0, 1, 0, 0, 1, 0, X, X));
      vecs.push_back(mk( 799, 524, X, X, X, X, X, 0, 0, 0, X, X));
      vecs.push_back(mk(   0,   0, X, 0, 0, 0, 0, 1, 1, 1, X, 1));
      // 800x600 with pix_en toggling every cycle, positive sync
      vecs.push_back(mk( 799,   0, X, 0, 0, 0, 0, X, X, X, X, X));
      vecs.push_back(mk( 800,   0, X, 0, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 839,   0, X, 0, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 840,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 967,   0, X, 1, 1, X, X, X, X, X, X, X));
      vecs.push_back(mk( 968,   0, X, 0, 1, X, X, 1, X, X, X, X));

      // reset state
      model_reset();
      #12;
      check("rst_hcount", int'(hcount), 0);
      check("rst_vcount", int'(vcount), 0);
      check("rst_hsync", int'(hsync), 1);
      check("rst_vsync", int'(vsync), 1);
      check("rst_hblnk", int'(hblnk), 0);
      check("rst_vblnk", int'(vblnk), 0);
      check("rst_frame_start", int'(frame_start), 0);
      check("rst_mode_ack", int'(mode_ack), 0);
      check("rst_mode_err", int'(mode_err), 0);
      check("rst_mode_active", int'(mode_active), 2);
      rst_n  = 1'b1;
      pix_en = 1'b1;

      foreach (vecs[i]) begin
         vec_t t;
         if (abort) break;
         t = vecs[i];
         run_until(t.h, t.v);
         if (abort) break;
         check($sformatf("v%0d_hcount", i), int'(hcount), t.h);
         check($sformatf("v%0d_vcount", i), int'(vcount), t.v);
         if (t.hs   != X) check($sformatf("v%0d_hsync", i), int'(hsync), t.hs);
         if (t.hb   != X) check($sformatf("v%0d_hblnk", i), int'(hblnk), t.hb);
         if (t.vs   != X) check($sformatf("v%0d_vsync", i), int'(vsync), t.vs);
         if (t.vb   != X) check($sformatf("v%0d_vblnk", i), int'(vblnk), t.vb);
         if (t.mode != X) check($sformatf("v%0d_mode_active", i), int'(mode_active), t.mode);
         if (t.fs   != X) check($sformatf("v%0d_frame_start", i), int'(frame_start), t.fs);
         if (t.ack  != X) check($sformatf("v%0d_mode_ack", i), int'(mode_ack), t.ack);
         if (t.err  != X) check($sformatf("v%0d_mode_err", i), int'(mode_err), t.err);
         if (t.rsel != X) begin
            mode_req_valid = 1'b1;
            mode_req_sel   = 2'(t.rsel);
         end
         if (t.tog != X) tog = (t.tog != 0);
      end

      // pix_en held low: everything freezes
      tog    = 1'b0;
      pix_en = 1'b0;
      repeat (5) step();
      check("hold_hcount", int'(hcount), 968);
      check("hold_hsync", int'(hsync), 0);
      check("hold_hblnk", int'(hblnk), 1);
      pix_en = 1'b1;
      step();
      step();
      check("resume_hcount", int'(hcount), 970);

      // pending request then asynchronous reset mid-frame
      mode_req_valid = 1'b1;
      mode_req_sel   = 2'd0;
      tog = 1'b1;
      run_until(500, 1);
      check("pre_rst_mode", int'(mode_active), 1);
      check("pre_rst_vsync", int'(vsync), 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_hcount", int'(hcount), 0);
      check("async_rst_vcount", int'(vcount), 0);
      check("async_rst_mode", int'(mode_active), 2);
      check("async_rst_hsync", int'(hsync), 1);
      check("async_rst_vsync", int'(vsync), 1);
      #2;
      rst_n  = 1'b1;
      tog    = 1'b0;
      pix_en = 1'b1;
      run_until(1048, 0);
      check("post_rst_hsync", int'(hsync), 0);
      check("post_rst_mode", int'(mode_active), 2);

      // frame periods and acknowledge count
      check("frame_start_count", fs_cyc.size(), 3);
      check("period_1024", (fs_cyc.size() > 0) ? fs_cyc[0] : -1, 1344 * 806);
      check("period_640_a", (fs_cyc.size() > 1) ? fs_cyc[1] - fs_cyc[0] : -1, 800 * 525);
      check("period_640_b", (fs_cyc.size() > 2) ? fs_cyc[2] - fs_cyc[1] : -1, 800 * 525);
      check("mode_ack_count", ack_cnt, 2);

      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL cycle_model mismatches=%0d required=0 first: %s", mism, first_mism);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
